// File: rtl/mag_stats_pkg.sv
// Shared types and default constants for the magnitude engine and its window statistics stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mag_stats_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int LOG2_WIN_DEF = 3;
    localparam int THR_HI_DEF   = 200;
    localparam int THR_LO_DEF   = 180;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/mag_window_buf.sv
// Circular buffer of the last 2**LOG2_WIN magnitude samples; read port shows the oldest entry.
// Latency: write lands at the clock edge; read of the slot under wr_ptr is combinational.
// Backpressure: none, a write is taken whenever wr_en is high.
// Ports: clk, rst (sync, active-high), flush (rewind pointer), wr_en/wr_data (write port),
//        rd_data (entry at wr_ptr, i.e. the sample about to be overwritten).
module mag_window_buf
    import mag_stats_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOG2_WIN = LOG2_WIN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [LOG2_WIN-1:0] PTR_ONE = 1;

    logic [DATA_W-1:0]   mem [2**LOG2_WIN];
    logic [LOG2_WIN-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;  // wraps naturally at 2**LOG2_WIN
        end
    end

    // Storage is never reset: the top only consumes rd_data once the window is full.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[wr_ptr];

endmodule

// File: rtl/mag_window_stats.sv
// Sliding-window mean, running max/min and hysteretic mean alarm over 8-bit magnitudes.
// Latency: max/min 1 cycle after accept; avg_out/avg_valid/alarm 2 edges (one cycle after the sum).
// Backpressure: none; samples are dropped while ena=0 or clear=1.
// Ports: clk, rst (sync, active-high), ena, clear, in_valid/in_data (sample in),
//        avg_out/avg_valid (window mean), max_out/min_out, full, alarm.
module mag_window_stats
    import mag_stats_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOG2_WIN = LOG2_WIN_DEF,
    parameter int THR_HI   = THR_HI_DEF,
    parameter int THR_LO   = THR_LO_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] min_out,
    output logic              full,
    output logic              alarm
);

    localparam int SUM_W = DATA_W + LOG2_WIN;
    localparam logic [LOG2_WIN:0]   CNT_ONE  = 1;
    localparam logic [LOG2_WIN:0]   CNT_LAST = (LOG2_WIN + 1)'((2**LOG2_WIN) - 1);
    localparam logic [DATA_W-1:0]   THR_HI_V = DATA_W'(THR_HI);
    localparam logic [DATA_W-1:0]   THR_LO_V = DATA_W'(THR_LO);

    state_t              state;
    logic [SUM_W-1:0]    sum;
    logic [LOG2_WIN:0]   fill_cnt;
    logic                avg_pend;   // a sample was accepted; its mean is due at the next enabled edge
    logic                accept;
    logic                flush;
    logic [DATA_W-1:0]   oldest;
    logic [DATA_W-1:0]   old_term;
    logic [SUM_W-1:0]    sum_nxt;
    logic [DATA_W-1:0]   avg_nxt;

    assign accept = in_valid && ena && !clear;
    assign flush  = ena && clear;

    mag_window_buf #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (accept),
        .wr_data (in_data),
        .rd_data (oldest)
    );

    // Until the window is full, nothing is evicted, so the buffer slot is not subtracted.
    assign old_term = (state == RUN) ? oldest : '0;
    assign sum_nxt  = sum + SUM_W'(in_data) - SUM_W'(old_term);
    assign avg_nxt  = sum[SUM_W-1:LOG2_WIN];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            sum       <= '0;
            fill_cnt  <= '0;
            avg_pend  <= 1'b0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            max_out   <= '0;
            min_out   <= '1;
            full      <= 1'b0;
            alarm     <= 1'b0;
        end else if (!ena) begin
            // Everything freezes; a pending mean update stays pending.
            avg_valid <= 1'b0;
        end else if (clear) begin
            // Same as reset except the alarm, which keeps its last decision.
            state     <= EMPTY;
            sum       <= '0;
            fill_cnt  <= '0;
            avg_pend  <= 1'b0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            max_out   <= '0;
            min_out   <= '1;
            full      <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (avg_pend && full) begin
                avg_out   <= avg_nxt;
                avg_valid <= 1'b1;
                if (avg_nxt >= THR_HI_V) begin
                    alarm <= 1'b1;
                end else if (avg_nxt <= THR_LO_V) begin
                    alarm <= 1'b0;
                end
            end
            avg_pend <= in_valid;
            if (in_valid) begin
                sum <= sum_nxt;
                if (in_data > max_out) max_out <= in_data;
                if (in_data < min_out) min_out <= in_data;
                case (state)
                    EMPTY: begin
                        state    <= FILL;
                        fill_cnt <= CNT_ONE;
                    end
                    FILL: begin
                        fill_cnt <= fill_cnt + CNT_ONE;
                        if (fill_cnt == CNT_LAST) begin
                            state <= RUN;
                            full  <= 1'b1;
                        end
                    end
                    RUN: begin
                        state <= RUN;
                    end
                    default: begin
                        state <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mag_window_stats.sv
// Self-checking bench for mag_window_stats: table-driven window segments plus hand sequences.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mag_window_stats;
    import mag_stats_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic [7:0] avg_out;
    logic       avg_valid;
    logic [7:0] max_out;
    logic [7:0] min_out;
    logic       full;
    logic       alarm;

    always #5 clk = ~clk;

    mag_window_stats #(
        .DATA_W   (8),
        .LOG2_WIN (3),
        .THR_HI   (200),
        .THR_LO   (180)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .avg_out   (avg_out),
        .avg_valid (avg_valid),
        .max_out   (max_out),
        .min_out   (min_out),
        .full      (full),
        .alarm     (alarm)
    );

    typedef struct {
        logic [7:0] avg;
        logic       alarm;
    } exp_t;

    typedef struct {
        logic [7:0] val;
        int         n;
        logic [7:0] exp_avg;
        logic       exp_alarm;
        logic [7:0] exp_max;
        logic [7:0] exp_min;
    } seg_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    // Reference model: last-8-sample queue, running extremes, hysteresis flag.
    int         win_q[$];
    logic [7:0] m_max = 8'd0;
    logic [7:0] m_min = 8'hFF;
    logic       m_alarm = 1'b0;
    bit         m_pend = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int win_mean();
        int s = 0;
        foreach (win_q[i]) s += win_q[i];
        return s / 8;
    endfunction

    // Drive one cycle and advance the model to what the coming edge should do.
    task automatic cyc(input logic v, input logic [7:0] d, input logic c,
                       input logic e, input logic r);
        int mean;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        clear    = c;
        ena      = e;
        rst      = r;
        if (r) begin
            win_q.delete();
            m_max = 8'd0; m_min = 8'hFF; m_alarm = 1'b0; m_pend = 1'b0;
        end else if (e) begin
            if (c) begin
                win_q.delete();
                m_max = 8'd0; m_min = 8'hFF; m_pend = 1'b0;
            end else begin
                if (m_pend) begin
                    mean = win_mean();
                    if (mean >= 200) m_alarm = 1'b1;
                    else if (mean <= 180) m_alarm = 1'b0;
                    sb.push_back('{avg: 8'(mean), alarm: m_alarm});
                end
                m_pend = 1'b0;
                if (v) begin
                    win_q.push_back(int'(d));
                    if (win_q.size() > 8) void'(win_q.pop_front());
                    if (d > m_max) m_max = d;
                    if (d < m_min) m_min = d;
                    m_pend = (win_q.size() == 8);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every avg_valid pulse must match the oldest expected mean.
    always @(negedge clk) begin
        if (avg_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_avg_valid: got avg_out %0d with no mean due", avg_out);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_avg_out", int'(avg_out), int'(mon_e.avg));
                chk("sb_alarm", int'(alarm), int'(mon_e.alarm));
            end
        end
    end

    seg_t tbl[5];

    initial begin
        tbl[0] = '{8'd13,  4, 8'd9,   1'b0, 8'd13,  8'd5};
        tbl[1] = '{8'd210, 8, 8'd210, 1'b1, 8'd210, 8'd5};
        tbl[2] = '{8'd190, 8, 8'd190, 1'b1, 8'd210, 8'd5};
        tbl[3] = '{8'd180, 8, 8'd180, 1'b0, 8'd210, 8'd5};
        tbl[4] = '{8'd199, 8, 8'd199, 1'b0, 8'd210, 8'd5};

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        chk("rst_avg_out", int'(avg_out), 0);
        chk("rst_avg_valid", int'(avg_valid), 0);
        chk("rst_max", int'(max_out), 0);
        chk("rst_min", int'(min_out), 255);
        chk("rst_full", int'(full), 0);
        chk("rst_alarm", int'(alarm), 0);

        // First fill: full only after the 8th accept, mean one cycle later.
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
        chk("fill7_full", int'(full), 0);
        chk("fill7_avg_valid", int'(avg_valid), 0);
        cyc(1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
        chk("fill8_full", int'(full), 1);
        chk("fill8_avg_valid", int'(avg_valid), 0);
        cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk("first_avg_valid", int'(avg_valid), 1);
        chk("first_avg_out", int'(avg_out), 5);

        // Back-to-back segments; scoreboard checks each mean, table checks the end state.
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < tbl[s].n; i++) cyc(1'b1, tbl[s].val, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("seg%0d_avg", s), int'(avg_out), int'(tbl[s].exp_avg));
            chk($sformatf("seg%0d_alarm", s), int'(alarm), int'(tbl[s].exp_alarm));
            chk($sformatf("seg%0d_max", s), int'(max_out), int'(tbl[s].exp_max));
            chk($sformatf("seg%0d_min", s), int'(min_out), int'(tbl[s].exp_min));
            chk($sformatf("seg%0d_full", s), int'(full), 1);
        end

        // clear collides with a sample and with the pending mean of the previous accept.
        cyc(1'b1, 8'd199, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 8'd77, 1'b1, 1'b1, 1'b0);
        chk("clr_avg_valid", int'(avg_valid), 0);
        chk("clr_full", int'(full), 0);
        chk("clr_max", int'(max_out), 0);
        chk("clr_min", int'(min_out), 255);
        chk("clr_avg_out", int'(avg_out), 0);
        chk("clr_alarm", int'(alarm), 0);
        cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk("clr_after_avg_valid", int'(avg_valid), 0);

        // ena low: samples dropped, state frozen.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'd50, 1'b0, 1'b0, 1'b0);
        chk("ena0_full", int'(full), 0);
        chk("ena0_max", int'(max_out), 0);
        chk("ena0_min", int'(min_out), 255);

        // A pending mean waits out an ena=0 stretch.
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'd100, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
            chk("hold_avg_valid", int'(avg_valid), 0);
        end
        cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk("resume_avg_valid", int'(avg_valid), 1);
        chk("resume_avg_out", int'(avg_out), 100);

        // Reset mid-fill.
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'd60, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        chk("rst2_avg_out", int'(avg_out), 0);
        chk("rst2_avg_valid", int'(avg_valid), 0);
        chk("rst2_max", int'(max_out), 0);
        chk("rst2_min", int'(min_out), 255);
        chk("rst2_full", int'(full), 0);
        chk("rst2_alarm", int'(alarm), 0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'd4, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_avg", int'(avg_out), 4);
        chk("post_rst_full", int'(full), 1);
        chk("post_rst_max", int'(max_out), 4);
        chk("post_rst_min", int'(min_out), 4);

        for (int i = 0; i < 3; i++) cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
